// File: rtl/alu_iter_pkg.sv
// Shared definitions for the iterative ALU: opcodes, flag bit positions,
// FSM state encoding and small combinational helpers.
package alu_iter_pkg;

    localparam int OPW = 6;
    localparam int FLW = 3;

    localparam logic [OPW-1:0] OP_ADD = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB = 6'b000001;
    localparam logic [OPW-1:0] OP_MOV = 6'b000010;
    localparam logic [OPW-1:0] OP_AND = 6'b000100;
    localparam logic [OPW-1:0] OP_OR  = 6'b000101;
    localparam logic [OPW-1:0] OP_XOR = 6'b000110;
    localparam logic [OPW-1:0] OP_NOT = 6'b000111;
    localparam logic [OPW-1:0] OP_SLL = 6'b011001;
    localparam logic [OPW-1:0] OP_SRL = 6'b011010;
    localparam logic [OPW-1:0] OP_SRA = 6'b011011;
    localparam logic [OPW-1:0] OP_MUL = 6'b100000;
    localparam logic [OPW-1:0] OP_DIV = 6'b100001;

    localparam int F_OVF  = 0;
    localparam int F_ZERO = 1;
    localparam int F_DZ   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    // Assemble the {dz, zero, ovf} flag vector by named bit position.
    function automatic logic [FLW-1:0] pack_flags(input logic dz, input logic zero, input logic ovf);
        logic [FLW-1:0] f;
        f         = {FLW{1'b0}};
        f[F_DZ]   = dz;
        f[F_ZERO] = zero;
        f[F_OVF]  = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between the EX-stage issuer (master) and alu_iter (slave).
interface alu_iter_if
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_valid;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic [FLW-1:0]   flags;
    logic             busy;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, res_valid, res, hi, flags, busy
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, res_valid, res, hi, flags, busy
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// Shared iterative datapath: signed Booth radix-2 multiply and unsigned
// restoring divide on one accumulator/shift register pair, WIDTH steps each.
// hi/lo present the value the registers take after the current step, so the
// caller can capture the final result on the same edge as the last step.
module alu_iter_muldiv
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_mode_e         mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // acc_r is one bit wider than the operands so the Booth subtract of the
    // most negative multiplicand and the restoring trial shift never overflow.
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] m_r;
    logic             qm1_r;
    logic [CW-1:0]    cnt_r;
    md_mode_e         mode_r;
    logic             run_r;

    logic [WIDTH:0]   m_ext_s;
    logic [WIDTH:0]   booth_sum_s;
    logic [WIDTH:0]   booth_acc_s;
    logic [WIDTH-1:0] booth_lo_s;
    logic [WIDTH:0]   div_shl_s;
    logic [WIDTH:0]   div_trial_s;
    logic [WIDTH:0]   div_acc_s;
    logic [WIDTH-1:0] div_lo_s;
    logic [WIDTH:0]   next_acc_s;
    logic [WIDTH-1:0] next_lo_s;

    // Booth step: add/subtract multiplicand per {q0, q-1}, then arithmetic shift right.
    always_comb begin
        m_ext_s = {m_r[WIDTH-1], m_r};
        case ({lo_r[0], qm1_r})
            2'b01:   booth_sum_s = acc_r + m_ext_s;
            2'b10:   booth_sum_s = acc_r - m_ext_s;
            default: booth_sum_s = acc_r;
        endcase
        booth_acc_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
        booth_lo_s  = {booth_sum_s[0], lo_r[WIDTH-1:1]};
    end

    // Restoring step: shift remainder left, keep the trial difference when non-negative.
    always_comb begin
        div_shl_s   = {acc_r[WIDTH-1:0], lo_r[WIDTH-1]};
        div_trial_s = div_shl_s - {1'b0, m_r};
        if (div_trial_s[WIDTH] == 1'b0) begin
            div_acc_s = div_trial_s;
            div_lo_s  = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_s = div_shl_s;
            div_lo_s  = {lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Select the step result for the active mode.
    always_comb begin
        if (mode_r == MD_MUL) begin
            next_acc_s = booth_acc_s;
            next_lo_s  = booth_lo_s;
        end else begin
            next_acc_s = div_acc_s;
            next_lo_s  = div_lo_s;
        end
    end

    assign done = run_r && (cnt_r == {CW{1'b0}});
    assign hi   = next_acc_s[WIDTH-1:0];
    assign lo   = next_lo_s;

    // Operand load on start, then one step per cycle until the counter reaches zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r  <= {(WIDTH + 1){1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            m_r    <= {WIDTH{1'b0}};
            qm1_r  <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            mode_r <= MD_MUL;
            run_r  <= 1'b0;
        end else if (start) begin
            acc_r  <= {(WIDTH + 1){1'b0}};
            lo_r   <= op_a;
            m_r    <= op_b;
            qm1_r  <= 1'b0;
            cnt_r  <= CNT_LAST;
            mode_r <= mode;
            run_r  <= 1'b1;
        end else if (run_r) begin
            acc_r <= next_acc_s;
            lo_r  <= next_lo_s;
            qm1_r <= lo_r[0];
            if (cnt_r == {CW{1'b0}}) begin
                run_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - {{(CW - 1){1'b0}}, 1'b1};
            end
        end else begin
            run_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// EX-stage ALU: single-cycle add/sub/logic/shift/move plus iterative signed
// MUL and unsigned DIV behind a valid/ready handshake. One op in flight.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    alu_iter_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e           state_r;
    state_e           state_s;
    logic             accept_s;
    logic             start_s;
    md_mode_e         mode_s;
    logic             b_zero_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_hi_s;
    logic [WIDTH-1:0] md_lo_s;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [SHW-1:0]   shamt_s;
    logic             shift_big_s;
    logic [WIDTH-1:0] sll_s;
    logic [WIDTH-1:0] srl_s;
    logic [WIDTH-1:0] sra_s;
    logic             sc_exec_s;
    logic [WIDTH-1:0] sc_res_s;
    logic             sc_ovf_s;

    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] hi_s;
    logic [FLW-1:0]   flags_s;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] hi_r;
    logic [FLW-1:0]   flags_r;
    logic             res_valid_r;
    logic             in_ready_r;
    logic             busy_r;

    assign accept_s = bus.in_valid && (state_r == S_IDLE);
    assign b_zero_s = (bus.b == {WIDTH{1'b0}});

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .mode  (mode_s),
        .op_a  (bus.a),
        .op_b  (bus.b),
        .done  (md_done_s),
        .hi    (md_hi_s),
        .lo    (md_lo_s)
    );

    // Arithmetic and shift candidates; an amount of WIDTH or more saturates.
    always_comb begin
        sum_s       = bus.a + bus.b;
        diff_s      = bus.a - bus.b;
        shamt_s     = bus.b[SHW-1:0];
        shift_big_s = |bus.b[WIDTH-1:SHW];
        if (shift_big_s) begin
            sll_s = {WIDTH{1'b0}};
            srl_s = {WIDTH{1'b0}};
            sra_s = {WIDTH{bus.a[MSB]}};
        end else begin
            sll_s = bus.a << shamt_s;
            srl_s = bus.a >> shamt_s;
            sra_s = $signed(bus.a) >>> shamt_s;
        end
    end

    // Pick the single-cycle result; MUL, DIV and unknown opcodes are not handled here.
    always_comb begin
        sc_exec_s = 1'b1;
        sc_res_s  = {WIDTH{1'b0}};
        sc_ovf_s  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_res_s = sum_s;
                sc_ovf_s = signed_ovf(bus.a[MSB], bus.b[MSB], sum_s[MSB]);
            end
            OP_SUB: begin
                sc_res_s = diff_s;
                sc_ovf_s = signed_ovf(bus.a[MSB], ~bus.b[MSB], diff_s[MSB]);
            end
            OP_MOV:  sc_res_s = bus.b;
            OP_AND:  sc_res_s = bus.a & bus.b;
            OP_OR:   sc_res_s = bus.a | bus.b;
            OP_XOR:  sc_res_s = bus.a ^ bus.b;
            OP_NOT:  sc_res_s = ~bus.b;
            OP_SLL:  sc_res_s = sll_s;
            OP_SRL:  sc_res_s = srl_s;
            OP_SRA:  sc_res_s = sra_s;
            default: sc_exec_s = 1'b0;
        endcase
    end

    // Next state and iterative-unit start; divide by zero bypasses iteration.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        mode_s  = MD_MUL;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (bus.op == OP_MUL) begin
                        state_s = S_MUL;
                        start_s = 1'b1;
                        mode_s  = MD_MUL;
                    end else if ((bus.op == OP_DIV) && !b_zero_s) begin
                        state_s = S_DIV;
                        start_s = 1'b1;
                        mode_s  = MD_DIV;
                    end else begin
                        state_s = S_DONE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (md_done_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Result/flag update; NOP and in-flight cycles hold the previous values.
    always_comb begin
        res_s   = res_r;
        hi_s    = hi_r;
        flags_s = flags_r;
        if (accept_s && sc_exec_s) begin
            res_s   = sc_res_s;
            hi_s    = {WIDTH{1'b0}};
            flags_s = pack_flags(1'b0, sc_res_s == {WIDTH{1'b0}}, sc_ovf_s);
        end else if (accept_s && (bus.op == OP_DIV) && b_zero_s) begin
            res_s   = {WIDTH{1'b1}};
            hi_s    = bus.a;
            flags_s = pack_flags(1'b1, 1'b0, 1'b0);
        end else if (md_done_s && (state_r == S_MUL)) begin
            res_s   = md_lo_s;
            hi_s    = md_hi_s;
            flags_s = pack_flags(1'b0, {md_hi_s, md_lo_s} == {(2 * WIDTH){1'b0}},
                                 md_hi_s != {WIDTH{md_lo_s[MSB]}});
        end else if (md_done_s && (state_r == S_DIV)) begin
            res_s   = md_lo_s;
            hi_s    = md_hi_s;
            flags_s = pack_flags(1'b0, md_lo_s == {WIDTH{1'b0}}, 1'b0);
        end else begin
            res_s   = res_r;
            hi_s    = hi_r;
            flags_s = flags_r;
        end
    end

    // State and output registers; status outputs are decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            res_r       <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            flags_r     <= {FLW{1'b0}};
            res_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            res_r       <= res_s;
            hi_r        <= hi_s;
            flags_r     <= flags_s;
            res_valid_r <= (state_s == S_DONE);
            in_ready_r  <= (state_s == S_IDLE);
            busy_r      <= (state_s == S_MUL) || (state_s == S_DIV);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res       = res_r;
    assign bus.hi        = hi_r;
    assign bus.flags     = flags_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter at WIDTH=16 (directed + random) and WIDTH=32 (random MUL/DIV).
module tb_alu_iter;
    import alu_iter_pkg::*;

    typedef struct {
        logic [63:0] res;
        logic [63:0] hi;
        logic [2:0]  flags;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t q16[$];
    exp_t q32[$];
    exp_t e16;
    exp_t e32;

    logic [63:0] mres[2];
    logic [63:0] mhi[2];
    logic [2:0]  mfl[2];

    logic [5:0] op_tab[14];

    always #5 clk = ~clk;

    // Cycle counter used for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    alu_iter_if #(.WIDTH(16)) bus16 ();
    alu_iter_if #(.WIDTH(32)) bus32 ();

    alu_iter #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(bus16));
    alu_iter #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(bus32));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference model: plain integer arithmetic on sign-extended values.
    task automatic ref_model(input int w, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] pr, input logic [63:0] ph, input logic [2:0] pf,
                             output logic [63:0] r, output logic [63:0] h, output logic [2:0] f);
        logic [63:0] mask;
        longint sa, sb, wide, smax, smin;
        bit ovf;
        int kind;
        mask = wmask(w);
        sa   = longint'(a << (64 - w)) >>> (64 - w);
        sb   = longint'(b << (64 - w)) >>> (64 - w);
        smax = (longint'(1) <<< (w - 1)) - longint'(1);
        smin = -(longint'(1) <<< (w - 1));
        r = pr; h = ph; f = pf; ovf = 1'b0; kind = 0; wide = 0;
        case (op)
            OP_ADD: begin wide = sa + sb; r = 64'(wide); ovf = (wide > smax) || (wide < smin); kind = 1; end
            OP_SUB: begin wide = sa - sb; r = 64'(wide); ovf = (wide > smax) || (wide < smin); kind = 1; end
            OP_MOV: begin r = b; kind = 1; end
            OP_AND: begin r = a & b; kind = 1; end
            OP_OR:  begin r = a | b; kind = 1; end
            OP_XOR: begin r = a ^ b; kind = 1; end
            OP_NOT: begin r = ~b; kind = 1; end
            OP_SLL: begin r = (b >= 64'(w)) ? 64'd0 : (a << b); kind = 1; end
            OP_SRL: begin r = (b >= 64'(w)) ? 64'd0 : (a >> b); kind = 1; end
            OP_SRA: begin wide = (b >= 64'(w)) ? (sa >>> 63) : (sa >>> b); r = 64'(wide); kind = 1; end
            OP_MUL: begin
                wide = sa * sb;
                r = 64'(wide) & mask;
                h = (64'(wide) >> w) & mask;
                f = {1'b0, wide == 0, (wide > smax) || (wide < smin)};
            end
            OP_DIV: begin
                if (b == 64'd0) begin
                    r = mask; h = a; f = 3'b100;
                end else begin
                    r = a / b; h = a % b; f = {1'b0, r == 64'd0, 1'b0};
                end
            end
            default: kind = 0;
        endcase
        if (kind == 1) begin
            r = r & mask;
            h = 64'd0;
            f = {1'b0, r == 64'd0, ovf};
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus16.in_ready : bus32.in_ready;
    endfunction

    task automatic drive(input int d, input logic v, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        if (d == 0) begin
            bus16.in_valid = v; bus16.op = op; bus16.a = a[15:0]; bus16.b = b[15:0];
        end else begin
            bus32.in_valid = v; bus32.op = op; bus32.a = a[31:0]; bus32.b = b[31:0];
        end
    endtask

    // Issue one op: wait for in_ready, present it for one edge, push the expectation.
    task automatic issue(input int d, input logic [5:0] op, input logic [63:0] a_in, input logic [63:0] b_in);
        exp_t e;
        int n, w;
        logic [63:0] a, b, r, h;
        logic [2:0] f;
        bit long_op;
        w = (d == 0) ? 16 : 32;
        a = a_in & wmask(w);
        b = b_in & wmask(w);
        n = 0;
        @(negedge clk);
        while (rdy(d) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL in_ready wait dut%0d: got 0 for %0d cycles, expected 1", d, n);
            return;
        end
        drive(d, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        ref_model(w, op, a, b, mres[d], mhi[d], mfl[d], r, h, f);
        long_op = (op == OP_MUL) || ((op == OP_DIV) && (b != 64'd0));
        e.res = r; e.hi = h; e.flags = f;
        e.cyc = cyc + (long_op ? w : 0);
        if (d == 0) q16.push_back(e); else q32.push_back(e);
        mres[d] = r; mhi[d] = h; mfl[d] = f;
        drive(d, 1'b0, op, a, b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q16.size() != 0 || q32.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", 64'(q16.size() + q32.size()), 64'd0);
    endtask

    // Monitor: one expectation per res_valid pulse; in_ready must be low while busy.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus16.res_valid === 1'b1) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++;
                    $display("FAIL u16 spurious res_valid: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e16 = q16.pop_front();
                    chk("u16 res", 64'(bus16.res), e16.res);
                    chk("u16 hi", 64'(bus16.hi), e16.hi);
                    chk("u16 flags", 64'(bus16.flags), 64'(e16.flags));
                    chk("u16 latency", 64'(cyc), 64'(e16.cyc));
                end
            end
            if (bus16.busy === 1'b1) chk("u16 in_ready while busy", 64'(bus16.in_ready), 64'd0);
            if (bus32.res_valid === 1'b1) begin
                checks++;
                if (q32.size() == 0) begin
                    errors++;
                    $display("FAIL u32 spurious res_valid: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e32 = q32.pop_front();
                    chk("u32 res", 64'(bus32.res), e32.res);
                    chk("u32 hi", 64'(bus32.hi), e32.hi);
                    chk("u32 flags", 64'(bus32.flags), 64'(e32.flags));
                    chk("u32 latency", 64'(cyc), 64'(e32.cyc));
                end
            end
            if (bus32.busy === 1'b1) chk("u32 in_ready while busy", 64'(bus32.in_ready), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra, rb;
        logic [5:0]  rop;
        op_tab = '{OP_ADD, OP_SUB, OP_MOV, OP_AND, OP_OR, OP_XOR, OP_NOT,
                   OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_DIV, 6'b010000, 6'b111111};
        for (int i = 0; i < 2; i++) begin
            mres[i] = 64'd0; mhi[i] = 64'd0; mfl[i] = 3'd0;
        end
        drive(0, 1'b0, 6'd0, 64'd0, 64'd0);
        drive(1, 1'b0, 6'd0, 64'd0, 64'd0);

        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("reset res", 64'(bus16.res), 64'd0);
        chk("reset hi", 64'(bus16.hi), 64'd0);
        chk("reset flags", 64'(bus16.flags), 64'd0);
        chk("reset res_valid", 64'(bus16.res_valid), 64'd0);
        chk("reset busy", 64'(bus32.busy), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", 64'(bus16.in_ready), 64'd1);

        // Directed WIDTH=16 cases
        issue(0, OP_ADD, 64'h7FFF, 64'h0001);
        issue(0, OP_SUB, 64'h0005, 64'h0005);
        issue(0, 6'b010000, 64'h1234, 64'h5678);
        issue(0, OP_MUL, 64'hFFFD, 64'h0007);
        // in_valid and operand changes while MUL runs must be ignored
        repeat (4) begin
            @(negedge clk);
            drive(0, 1'b1, OP_ADD, 64'($urandom), 64'($urandom));
        end
        @(negedge clk);
        drive(0, 1'b0, OP_ADD, 64'd0, 64'd0);
        issue(0, OP_MUL, 64'h4000, 64'h0004);
        issue(0, OP_MUL, 64'h8000, 64'h8000);
        issue(0, OP_DIV, 64'd100, 64'd7);
        issue(0, OP_DIV, 64'h1234, 64'h0000);
        issue(0, OP_SRA, 64'h8000, 64'h0020);
        issue(0, OP_SLL, 64'h0001, 64'h0004);
        issue(0, OP_SRL, 64'hABCD, 64'd16);
        issue(0, OP_SUB, 64'h8000, 64'h0001);
        issue(0, OP_NOT, 64'h0000, 64'hFFFF);

        // Random WIDTH=16 ops, including unknown opcodes
        for (int i = 0; i < 80; i++) begin
            rop = op_tab[$urandom_range(0, 13)];
            ra  = 64'($urandom);
            rb  = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 20)) : 64'($urandom);
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom_range(0, 63));
            issue(0, rop, ra, rb);
        end
        drain();

        // Reset during iteration 8 of a DIV
        @(negedge clk);
        drive(0, 1'b1, OP_DIV, 64'd100, 64'd7);
        @(posedge clk);
        #1 drive(0, 1'b0, OP_DIV, 64'd100, 64'd7);
        repeat (8) @(posedge clk);
        #2;
        chk("busy before abort", 64'(bus16.busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("abort res", 64'(bus16.res), 64'd0);
        chk("abort hi", 64'(bus16.hi), 64'd0);
        chk("abort flags", 64'(bus16.flags), 64'd0);
        chk("abort res_valid", 64'(bus16.res_valid), 64'd0);
        chk("abort busy", 64'(bus16.busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mres[i] = 64'd0; mhi[i] = 64'd0; mfl[i] = 3'd0;
        end
        @(negedge clk);
        chk("in_ready after abort", 64'(bus16.in_ready), 64'd1);
        repeat (24) @(negedge clk);
        issue(0, 6'b111111, 64'h1111, 64'h2222);

        // WIDTH=32 MUL/DIV: boundaries then random
        issue(1, OP_MUL, 64'h8000_0000, 64'h8000_0000);
        issue(1, OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        issue(1, OP_DIV, 64'hFFFF_FFFF, 64'd1);
        issue(1, OP_DIV, 64'hDEAD_BEEF, 64'd0);
        issue(1, OP_DIV, 64'd5, 64'd9);
        for (int i = 0; i < 50; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra  = 64'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 300)) : 64'($urandom);
            issue(1, rop, ra, rb);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
